// File: rtl/player_mover_pkg.sv
// Shared types and constants for the player movement logic.
//   - dir_e       : 2-bit move direction codes (up/down/left/right).
//   - pm_state_e  : player_mover FSM state encoding.
//   - Def*        : default start/exit tile coordinates, also used by the renderer.
package player_mover_pkg;

  localparam int unsigned CoordW = 5;
  localparam int unsigned CntW   = 24;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,  // y + 1
    DirDown  = 2'd1,  // y - 1
    DirLeft  = 2'd2,  // x - 1
    DirRight = 2'd3   // x + 1
  } dir_e;

  typedef enum logic [1:0] {
    PmIdle  = 2'd0,
    PmCheck = 2'd1,
    PmCool  = 2'd2
  } pm_state_e;

  localparam int unsigned DefStartX = 1;
  localparam int unsigned DefStartY = 1;
  localparam int unsigned DefExitX  = 18;
  localparam int unsigned DefExitY  = 8;

endpackage

// File: rtl/player_mover_tile_step.sv
// Combinational one-tile step: returns the neighbouring tile of (pos_x_i, pos_y_i)
// in direction dir_i. Arithmetic wraps modulo 32; the wall lookup treats the
// wrapped coordinates as walls, so no bounds handling is needed here.
// Ports:
//   pos_x_i, pos_y_i : current tile
//   dir_i            : step direction
//   tgt_x_o, tgt_y_o : neighbouring tile
module player_mover_tile_step
  import player_mover_pkg::*;
(
  input  logic [CoordW-1:0] pos_x_i,
  input  logic [CoordW-1:0] pos_y_i,
  input  dir_e              dir_i,
  output logic [CoordW-1:0] tgt_x_o,
  output logic [CoordW-1:0] tgt_y_o
);

  always_comb begin
    tgt_x_o = pos_x_i;
    tgt_y_o = pos_y_i;
    unique case (dir_i)
      DirUp:    tgt_y_o = pos_y_i + CoordW'(1);
      DirDown:  tgt_y_o = pos_y_i - CoordW'(1);
      DirLeft:  tgt_x_o = pos_x_i - CoordW'(1);
      DirRight: tgt_x_o = pos_x_i + CoordW'(1);
      default:  ;
    endcase
  end

endmodule

// File: rtl/player_mover.sv
// Player mover: accepts one-step move requests, queries the combinational wall
// lookup with the target tile, then commits the move or reports a bump, and
// enforces a cooldown before the next request.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   move_valid/move_dir : move request and direction (see dir_e)
//   move_ready          : high when a request is accepted this cycle (IDLE)
//   tile_x/tile_y       : query tile to wall lookup, is_wall is its answer
//   pos_x/pos_y         : current player tile
//   moved/blocked       : one-cycle result pulses, coincident with new pos
//   at_exit             : level, player stands on the exit tile
module player_mover
  import player_mover_pkg::*;
#(
  parameter int unsigned START_X         = DefStartX,
  parameter int unsigned START_Y         = DefStartY,
  parameter int unsigned EXIT_X          = DefExitX,
  parameter int unsigned EXIT_Y          = DefExitY,
  parameter int unsigned COOLDOWN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              move_valid,
  input  logic [1:0]        move_dir,
  output logic              move_ready,
  output logic [CoordW-1:0] tile_x,
  output logic [CoordW-1:0] tile_y,
  input  logic              is_wall,
  output logic [CoordW-1:0] pos_x,
  output logic [CoordW-1:0] pos_y,
  output logic              moved,
  output logic              blocked,
  output logic              at_exit
);

  localparam logic [CoordW-1:0] StartX = CoordW'(START_X);
  localparam logic [CoordW-1:0] StartY = CoordW'(START_Y);
  localparam logic [CoordW-1:0] ExitX  = CoordW'(EXIT_X);
  localparam logic [CoordW-1:0] ExitY  = CoordW'(EXIT_Y);
  localparam bit                CoolEn = (COOLDOWN_CYCLES != 0);
  // The CHECK cycle is itself the first decision cycle, so COOL runs one fewer.
  localparam logic [CntW-1:0]   CoolLoad =
      (COOLDOWN_CYCLES == 0) ? '0 : CntW'(COOLDOWN_CYCLES - 1);

  pm_state_e         state_q, state_d;
  logic [CoordW-1:0] pos_x_q, pos_x_d;
  logic [CoordW-1:0] pos_y_q, pos_y_d;
  logic [CoordW-1:0] tile_x_q, tile_x_d;
  logic [CoordW-1:0] tile_y_q, tile_y_d;
  logic              moved_q, moved_d;
  logic              blocked_q, blocked_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CoordW-1:0] tgt_x, tgt_y;

  player_mover_tile_step u_tile_step (
    .pos_x_i (pos_x_q),
    .pos_y_i (pos_y_q),
    .dir_i   (dir_e'(move_dir)),
    .tgt_x_o (tgt_x),
    .tgt_y_o (tgt_y)
  );

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    tile_x_d  = tile_x_q;
    tile_y_d  = tile_y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      PmIdle: begin
        if (move_valid) begin
          // move_dir only matters here; the target is frozen in tile_*.
          tile_x_d = tgt_x;
          tile_y_d = tgt_y;
          state_d  = PmCheck;
        end
      end
      PmCheck: begin
        if (!is_wall) begin
          pos_x_d = tile_x_q;
          pos_y_d = tile_y_q;
          moved_d = 1'b1;
        end else begin
          blocked_d = 1'b1;
        end
        if (CoolEn) begin
          state_d = PmCool;
          cnt_d   = CoolLoad;
        end else begin
          state_d = PmIdle;
        end
      end
      PmCool: begin
        if (cnt_q == '0) begin
          state_d = PmIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = PmIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PmIdle;
      pos_x_q   <= StartX;
      pos_y_q   <= StartY;
      tile_x_q  <= StartX;
      tile_y_q  <= StartY;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      tile_x_q  <= tile_x_d;
      tile_y_q  <= tile_y_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
      cnt_q     <= cnt_d;
    end
  end

  assign move_ready = (state_q == PmIdle);
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign moved      = moved_q;
  assign blocked    = blocked_q;
  assign at_exit    = (pos_x_q == ExitX) && (pos_y_q == ExitY);

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover. Three instances share clock and reset:
//   [0] defaults (start (1,1), cooldown 4)
//   [1] start (17,8), next to the exit
//   [2] cooldown 0
// A small maze model answers each instance's wall lookup.
module tb_player_mover;

  logic       clk;
  logic       rst_n;
  logic       mv_valid [3];
  logic [1:0] mv_dir   [3];
  logic       ready    [3];
  logic [4:0] tile_x   [3];
  logic [4:0] tile_y   [3];
  logic       is_wall  [3];
  logic [4:0] pos_x    [3];
  logic [4:0] pos_y    [3];
  logic       moved    [3];
  logic       blocked  [3];
  logic       at_exit  [3];

  int tests = 0;
  int fails = 0;

  // Maze: 20x10 box with border walls, plus one interior wall at (4,1).
  function automatic logic wall_at(input logic [4:0] x, input logic [4:0] y);
    return (x == 5'd0) || (y == 5'd0) || (x >= 5'd19) || (y >= 5'd9) ||
           (x == 5'd4 && y == 5'd1);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) is_wall[i] = wall_at(tile_x[i], tile_y[i]);
  end

  player_mover #(.COOLDOWN_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .move_valid(mv_valid[0]), .move_dir(mv_dir[0]),
    .move_ready(ready[0]), .tile_x(tile_x[0]), .tile_y(tile_y[0]), .is_wall(is_wall[0]),
    .pos_x(pos_x[0]), .pos_y(pos_y[0]), .moved(moved[0]), .blocked(blocked[0]),
    .at_exit(at_exit[0])
  );

  player_mover #(.START_X(17), .START_Y(8), .COOLDOWN_CYCLES(4)) u_exit (
    .clk(clk), .rst_n(rst_n), .move_valid(mv_valid[1]), .move_dir(mv_dir[1]),
    .move_ready(ready[1]), .tile_x(tile_x[1]), .tile_y(tile_y[1]), .is_wall(is_wall[1]),
    .pos_x(pos_x[1]), .pos_y(pos_y[1]), .moved(moved[1]), .blocked(blocked[1]),
    .at_exit(at_exit[1])
  );

  player_mover #(.COOLDOWN_CYCLES(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .move_valid(mv_valid[2]), .move_dir(mv_dir[2]),
    .move_ready(ready[2]), .tile_x(tile_x[2]), .tile_y(tile_y[2]), .is_wall(is_wall[2]),
    .pos_x(pos_x[2]), .pos_y(pos_y[2]), .moved(moved[2]), .blocked(blocked[2]),
    .at_exit(at_exit[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One single-cycle request on instance idx (cooldown 4), checked through to
  // move_ready returning. Called on a negedge; returns on a negedge.
  task automatic move1(input int idx, input logic [1:0] dir, input logic [4:0] tx,
                       input logic [4:0] ty, input logic exp_moved, input logic [4:0] px,
                       input logic [4:0] py, input string tag);
    int low = 0;
    mv_valid[idx] = 1'b1;
    mv_dir[idx]   = dir;
    @(negedge clk);
    mv_valid[idx] = 1'b0;
    chk({tag, "/tile_x"}, tile_x[idx], tx);
    chk({tag, "/tile_y"}, tile_y[idx], ty);
    if (!ready[idx]) low++;
    @(negedge clk);
    chk({tag, "/moved"}, moved[idx], exp_moved);
    chk({tag, "/blocked"}, blocked[idx], !exp_moved);
    chk({tag, "/pos_x"}, pos_x[idx], px);
    chk({tag, "/pos_y"}, pos_y[idx], py);
    if (!ready[idx]) low++;
    @(negedge clk);
    chk({tag, "/pulse_width"}, moved[idx] | blocked[idx], 1'b0);
    if (!ready[idx]) low++;
    repeat (2) begin
      @(negedge clk);
      if (!ready[idx]) low++;
    end
    @(negedge clk);
    chk({tag, "/ready_low_cycles"}, low, 5);
    chk({tag, "/ready_back"}, ready[idx], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mv_valid[i] = 1'b0;
      mv_dir[i]   = 2'd0;
    end

    // Reset values, and no accept while reset is held.
    @(negedge clk);
    mv_valid[0] = 1'b1;
    @(negedge clk);
    mv_valid[0] = 1'b0;
    chk("rst/tile_x_no_accept", tile_x[0], 5'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/pos_x", pos_x[0], 5'd1);
    chk("rst/pos_y", pos_y[0], 5'd1);
    chk("rst/tile_x", tile_x[0], 5'd1);
    chk("rst/tile_y", tile_y[0], 5'd1);
    chk("rst/ready", ready[0], 1'b1);
    chk("rst/moved", moved[0], 1'b0);
    chk("rst/blocked", blocked[0], 1'b0);
    chk("rst/at_exit", at_exit[0], 1'b0);
    chk("rst/exit_inst_pos_x", pos_x[1], 5'd17);
    chk("rst/exit_inst_at_exit", at_exit[1], 1'b0);

    // Bumps into the left and bottom borders.
    move1(0, 2'd2, 5'd0, 5'd1, 1'b0, 5'd1, 5'd1, "left_bump");
    move1(0, 2'd1, 5'd1, 5'd0, 1'b0, 5'd1, 5'd1, "down_bump");

    // Up, then asynchronous reset in the middle of COOL.
    mv_valid[0] = 1'b1;
    mv_dir[0]   = 2'd0;
    @(negedge clk);
    mv_valid[0] = 1'b0;
    chk("up/tile_y", tile_y[0], 5'd2);
    chk("up/pos_y_before", pos_y[0], 5'd1);
    @(negedge clk);
    chk("up/moved", moved[0], 1'b1);
    chk("up/pos_y", pos_y[0], 5'd2);
    @(negedge clk);
    chk("up/in_cool", ready[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/pos_y", pos_y[0], 5'd1);
    chk("midrst/tile_y", tile_y[0], 5'd1);
    chk("midrst/ready", ready[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst/no_pulse", moved[0] | blocked[0], 1'b0);
      chk("midrst/ready_idle", ready[0], 1'b1);
    end

    // Right x3 with valid held: one accept every 6 cycles.
    mv_valid[0] = 1'b1;
    mv_dir[0]   = 2'd3;
    for (int k = 0; k < 3; k++) begin
      logic [4:0] tx;
      logic [4:0] px;
      tx = 5'(2 + k);
      px = (k == 2) ? 5'd3 : tx;
      @(negedge clk);
      chk("right3/tile_x", tile_x[0], tx);
      @(negedge clk);
      chk("right3/moved", moved[0], (k != 2));
      chk("right3/blocked", blocked[0], (k == 2));
      chk("right3/pos_x", pos_x[0], px);
      repeat (3) @(negedge clk);
      chk("right3/ready_low", ready[0], 1'b0);
      @(negedge clk);
      chk("right3/ready_high", ready[0], 1'b1);
      chk("right3/tile_held", tile_x[0], tx);
    end
    mv_valid[0] = 1'b0;
    @(negedge clk);
    chk("right3/final_pos_x", pos_x[0], 5'd3);
    chk("right3/final_pos_y", pos_y[0], 5'd1);

    // Onto and off the exit tile.
    move1(1, 2'd3, 5'd18, 5'd8, 1'b1, 5'd18, 5'd8, "exit_in");
    chk("exit_in/at_exit", at_exit[1], 1'b1);
    move1(1, 2'd2, 5'd17, 5'd8, 1'b1, 5'd17, 5'd8, "exit_out");
    chk("exit_out/at_exit", at_exit[1], 1'b0);

    // Zero cooldown: back-to-back accepts; dir change during CHECK is ignored.
    mv_valid[2] = 1'b1;
    mv_dir[2]   = 2'd3;
    @(negedge clk);
    chk("fast/tile_x1", tile_x[2], 5'd2);
    chk("fast/ready_check", ready[2], 1'b0);
    mv_dir[2] = 2'd0;
    @(negedge clk);
    chk("fast/tile_x_held", tile_x[2], 5'd2);
    chk("fast/tile_y_held", tile_y[2], 5'd1);
    chk("fast/moved1", moved[2], 1'b1);
    chk("fast/pos_x1", pos_x[2], 5'd2);
    chk("fast/ready1", ready[2], 1'b1);
    mv_dir[2] = 2'd3;
    @(negedge clk);
    chk("fast/tile_x2", tile_x[2], 5'd3);
    chk("fast/moved_drop", moved[2], 1'b0);
    @(negedge clk);
    chk("fast/moved2", moved[2], 1'b1);
    chk("fast/pos_x2", pos_x[2], 5'd3);
    chk("fast/pos_y2", pos_y[2], 5'd1);
    chk("fast/ready2", ready[2], 1'b1);
    mv_valid[2] = 1'b0;
    @(negedge clk);
    chk("fast/no_accept_tile", tile_x[2], 5'd3);
    chk("fast/idle_ready", ready[2], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
